sccb_wr_ctrl: RTL and testbench
===============================

Name: sccb_wr_ctrl

Overview:
- Single-register SCCB (I2C-compatible) write engine for the OV5640 camera.
- Sits directly downstream of the OV5640 register-config sequencer.
- Accepts one {REG_ADDR[15:0], REG_VAL[7:0]} word per cfg_start pulse and serialises it as a 4-phase write: ID, addr_hi, addr_lo, data.
- Pulses cfg_end when the STOP condition completes, so the sequencer can issue the next word.

Parameters:
- SYS_CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- SCL_FREQ, 250_000: target SCL frequency in Hz.
- DEV_ID, 8'h78: 8-bit write device ID (7-bit 0x3C with R/W=0).
- QDIV, SYS_CLK_FREQ/(SCL_FREQ*4): sys_clk cycles per SCL quarter-period. Must be ≥2. Derived as a localparam unless overridden in simulation.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- cfg_start  in  1  one-cycle request to write cfg_data.
- cfg_data  in  24  {REG_ADDR[15:0], REG_VAL[7:0]}.
- cfg_end  out  1  one-cycle pulse: transaction finished.
- busy  out  1  high while a transaction is in progress.
- ack_err  out  1  one-cycle pulse with cfg_end when a NACK was seen (optional feature only).
- scl  out  1  SCCB clock, push-pull.
- sda_oe  out  1  1 = pull SDA low, 0 = release (top level builds the open-drain pad).
- sda_in  in  1  SDA pad readback.

Behaviour:
- Reset (async, sys_rst=1):
  - State goes to IDLE; quarter counter, bit counter and byte counter cleared.
  - scl=1, sda_oe=0, cfg_end=0, busy=0, ack_err=0.
  - Reset asserted mid-transaction aborts immediately; the bus is released with no STOP.
- Quarter timer: qcnt counts 0..QDIV-1, and the quarter index q (0..3) advances when qcnt wraps. All SCL/SDA changes occur on quarter boundaries.
- Sequence of states: IDLE → START → BYTE (4 bytes × 9 bit slots) → STOP → DONE → IDLE.
- IDLE:
  - scl=1, sda_oe=0.
  - cfg_start=1 latches shift_reg = {DEV_ID, cfg_data}, sets busy=1 from the next cycle and enters START.
  - cfg_start while busy=1 is ignored; cfg_data is not re-sampled.
- START quarters: q0, q1 = SCL 1 / SDA released; q2 = SCL 1 / SDA low; q3 = SCL 0 / SDA low.
- Bit slot quarters:
  - q0: SCL 0; SDA driven with the current MSB (sda_oe = ~bit).
  - q1, q2: SCL 1.
  - q3: SCL 0.
  - After q3 the shift register shifts left by one.
- Bit order: MSB first, bytes in the order DEV_ID, addr[15:8], addr[7:0], val.
- ACK slot: the 9th slot of each byte has sda_oe=0 for all four quarters; sda_in is sampled at the end of q2.
- STOP quarters: q0 = SCL 0 / SDA low; q1 = SCL 1 / SDA low; q2, q3 = SCL 1 / SDA released.
- DONE: lasts one cycle. cfg_end=1, busy=0 in that same cycle, then IDLE.
- cfg_start is accepted in the cycle after DONE or later.
- Latency: cfg_start sampled at edge N → cfg_end high during cycle N+1+152·QDIV (38 phases × 4 quarters), exactly one cycle wide.
- cfg_end is never asserted outside DONE.
- Counters: bit counter is 4 bits (0..8) and wraps per byte; byte counter is 2 bits (0..3). Byte 3 ACK leads to STOP.

Optional Feature:
- Macro: SCCB_ACK_CHK_EN.
- Defined:
  - sda_in=1 sampled in any ACK slot sets nack_flag.
  - On leaving that ACK slot the FSM jumps straight to STOP, skipping the remaining bytes.
  - ack_err pulses together with cfg_end; nack_flag clears in IDLE.
- Undefined:
  - ACK slots are SCCB don't-care bits; sda_in is ignored.
  - ack_err is tied to 0.
  - Timing is always the full 152·QDIV.

Test Plan:
- Reset check: sys_rst=1 at any time → scl=1, sda_oe=0, busy=0, cfg_end=0 within the same cycle; sys_rst=0 → outputs hold idle until cfg_start.
- Basic write (QDIV=4): cfg_start with cfg_data=24'h300842 → SDA sampled on SCL rising edges yields bytes 78, 30, 08, 42 with released ACK slots; START/STOP ordering correct; cfg_end exactly 609 cycles after the start edge; one-cycle pulse.
- Back-to-back writes: cfg_start the cycle after cfg_end, data 24'h3004FF then 24'h300E58 → two complete frames, STOP-to-START gap ≥4 quarters, two cfg_end pulses.
- Start while busy: second cfg_start with 24'h123456 at cycle 100 of a transaction → ignored; frame still carries the first word; single cfg_end.
- Mid-transaction reset: sys_rst pulse during the addr_lo byte → immediate release (scl=1, sda_oe=0, busy=0); next cfg_start with 24'h310311 produces a clean full frame.
- NACK (SCCB_ACK_CHK_EN defined): sda_in held 1 during the first ACK slot → STOP follows immediately; cfg_end and ack_err pulse together at 4+36+4=44 quarters (177 cycles at QDIV=4); without the macro the full 609-cycle frame runs and ack_err=0.

Source files
------------

// File: rtl/sccb_wr_ctrl_if.sv
// sccb_wr_ctrl_if: config handshake and SCCB pad signals of the OV5640 register write engine
// Ports (signals):
//   cfg_start, cfg_data[23:0]     request and {REG_ADDR, REG_VAL} word from the sequencer
//   cfg_end, busy, ack_err        completion pulse, activity flag, NACK pulse
//   scl, sda_oe, sda_in           SCCB clock, SDA pull-down enable, SDA pad readback
// Modports: slave = write engine, master = sequencer/pad side
interface sccb_wr_ctrl_if;
    logic        cfg_start;
    logic [23:0] cfg_data;
    logic        cfg_end;
    logic        busy;
    logic        ack_err;
    logic        scl;
    logic        sda_oe;
    logic        sda_in;
    modport slave (input cfg_start, cfg_data, sda_in, output cfg_end, busy, ack_err, scl, sda_oe);
    modport master (output cfg_start, cfg_data, sda_in, input cfg_end, busy, ack_err, scl, sda_oe);
endinterface

// File: rtl/sccb_wr_ctrl.sv
// sccb_wr_ctrl: single-register SCCB write engine (ID, addr_hi, addr_lo, data) for the OV5640
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   bus (slave)        cfg_start/cfg_data in, cfg_end/busy/ack_err out, scl/sda_oe out, sda_in in
// Optional: define SCCB_ACK_CHK_EN to abort to STOP on a NACK and report it on ack_err.
module sccb_wr_ctrl #(
    parameter int          SYS_CLK_FREQ = 50_000_000,
    parameter int          SCL_FREQ     = 250_000,
    parameter logic [7:0]  DEV_ID       = 8'h78,
    parameter int          QDIV         = SYS_CLK_FREQ / (SCL_FREQ * 4)
) (
    input logic            sys_clk,
    input logic            sys_rst,
    sccb_wr_ctrl_if.slave  bus
);
    localparam int QW = QDIV > 1 ? $clog2(QDIV) : 1;
    typedef enum logic [2:0] {IDLE, START, BYTE, STOP, DONE} state_t;
    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    q_q, q_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   shift_q, shift_d;
    logic          nack_q, nack_d;
    logic          qwrap, pend;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            nack_q  <= nack_d;
        end
    end
    // qwrap ends a quarter, pend ends a whole phase (START, one bit slot, STOP)
    assign qwrap = qcnt_q == QW'(QDIV - 1);
    assign pend  = qwrap && q_q == 2'd3;
    always_comb begin
        state_d = state_q;
        qcnt_d  = qwrap ? '0 : qcnt_q + 1'b1;
        q_d     = qwrap ? q_q + 2'd1 : q_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        nack_d  = nack_q;
        case (state_q)
            IDLE: begin
                qcnt_d = '0;
                q_d    = '0;
                bit_d  = '0;
                byte_d = '0;
                nack_d = 1'b0;
                if (bus.cfg_start) begin
                    shift_d = {DEV_ID, bus.cfg_data};
                    state_d = START;
                end
            end
            START: state_d = pend ? BYTE : START;
            BYTE: begin
`ifdef SCCB_ACK_CHK_EN
                if (bit_q == 4'd8 && q_q == 2'd2 && qwrap && bus.sda_in)
                    nack_d = 1'b1;
`endif
                // the ACK slot does not shift: 32 data bits fill the register exactly
                if (pend && bit_q == 4'd8) begin
                    bit_d   = '0;
                    byte_d  = byte_q + 2'd1;
                    state_d = (byte_q == 2'd3 || nack_q) ? STOP : BYTE;
                end else if (pend) begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {shift_q[30:0], 1'b0};
                end
            end
            STOP: state_d = pend ? DONE : STOP;
            default: state_d = IDLE;
        endcase
    end
    assign bus.scl     = state_q == START ? q_q != 2'd3 :
                         state_q == BYTE  ? (q_q == 2'd1 || q_q == 2'd2) :
                         state_q == STOP  ? q_q != 2'd0 : 1'b1;
    assign bus.sda_oe  = state_q == START ? q_q[1] :
                         state_q == BYTE  ? (bit_q != 4'd8 && !shift_q[31]) :
                         state_q == STOP  ? !q_q[1] : 1'b0;
    assign bus.cfg_end = state_q == DONE;
    assign bus.busy    = state_q == START || state_q == BYTE || state_q == STOP;
`ifdef SCCB_ACK_CHK_EN
    assign bus.ack_err = state_q == DONE && nack_q;
`else
    assign bus.ack_err = 1'b0;
`endif
endmodule

// File: tb/tb_sccb_wr_ctrl.sv
// tb_sccb_wr_ctrl: directed self-checking bench for sccb_wr_ctrl at QDIV=4
module tb_sccb_wr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    sccb_wr_ctrl_if bus();
    sccb_wr_ctrl #(.QDIV(4)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    logic [36:0] fq[$];
    int          nq[$];
    logic [36:0] cur = '0;
    int          nbits = 0;
    logic        pscl = 1'b1;
    logic        psda = 1'b1;
    int          stop_cyc = 0;
    int          last_gap = 0;
    int          end_cnt = 0;
    always @(negedge clk) begin
        if (pscl && bus.scl && psda && bus.sda_oe) begin
            cur = '0;
            nbits = 0;
            last_gap = cyc - stop_cyc;
        end else if (pscl && bus.scl && !psda && !bus.sda_oe) begin
            fq.push_back(cur);
            nq.push_back(nbits);
            stop_cyc = cyc;
        end else if (!pscl && bus.scl) begin
            cur = {cur[35:0], ~bus.sda_oe};
            nbits++;
        end
        if (bus.cfg_end) end_cnt++;
        pscl = bus.scl;
        psda = ~bus.sda_oe;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [36:0] ef(input logic [23:0] d);
        return {8'h78, 1'b1, d[23:16], 1'b1, d[15:8], 1'b1, d[7:0], 1'b1, 1'b0};
    endfunction
    task automatic do_write(input logic [23:0] d, input int inj, output int lat, output logic ack);
        int c0;
        lat = -1;
        ack = 1'bx;
        bus.cfg_start = 1'b1;
        bus.cfg_data = d;
        c0 = cyc;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            bus.cfg_start = (i == inj);
            if (i == inj) bus.cfg_data = 24'h123456;
            if (i == 1) chk("busy_rise", bus.busy, 1'b1);
            if (bus.cfg_end) begin
                lat = cyc - c0;
                ack = bus.ack_err;
                chk("busy_done", bus.busy, 1'b0);
                break;
            end
        end
        chk("no_timeout", lat > 0, 1'b1);
        @(negedge clk);
        chk("end_pulse", bus.cfg_end, 1'b0);
    endtask
    task automatic chk_frame(input string tag, input logic [23:0] d);
        chk({tag, "_cnt"}, fq.size(), 1);
        if (fq.size() > 0) begin
            chk({tag, "_bits"}, nq.pop_front(), 37);
            chk({tag, "_data"}, fq.pop_front(), ef(d));
        end
        fq.delete();
        nq.delete();
    endtask
    initial begin
        int lat;
        logic ack;
        int e0;
        bus.cfg_start = 1'b0;
        bus.cfg_data = '0;
        bus.sda_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", bus.scl, 1'b1);
        chk("rst_sda", bus.sda_oe, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_end", bus.cfg_end, 1'b0);
        chk("rst_ack", bus.ack_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_scl", bus.scl, 1'b1);
        chk("idle_busy", bus.busy, 1'b0);
        do_write(24'h300842, 0, lat, ack);
        chk("basic_lat", lat, 609);
        chk("basic_ack", ack, 1'b0);
        chk_frame("basic", 24'h300842);
        do_write(24'h3004FF, 0, lat, ack);
        chk("b2b1_lat", lat, 609);
        do_write(24'h300E58, 0, lat, ack);
        chk("b2b2_lat", lat, 609);
        chk("b2b_gap", last_gap >= 16, 1'b1);
        chk("b2b_cnt", fq.size(), 2);
        if (fq.size() == 2) begin
            chk("b2b1_data", fq.pop_front(), ef(24'h3004FF));
            chk("b2b2_data", fq.pop_front(), ef(24'h300E58));
        end
        fq.delete();
        nq.delete();
        repeat (4) @(negedge clk);
        e0 = end_cnt;
        do_write(24'h3A1B2C, 100, lat, ack);
        repeat (20) @(negedge clk);
        chk("busy_lat", lat, 609);
        chk("busy_ends", end_cnt - e0, 1);
        chk_frame("busy", 24'h3A1B2C);
        bus.cfg_start = 1'b1;
        bus.cfg_data = 24'h3004FF;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        repeat (330) @(negedge clk);
        chk("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_scl", bus.scl, 1'b1);
        chk("mid_sda", bus.sda_oe, 1'b0);
        chk("mid_rbusy", bus.busy, 1'b0);
        chk("mid_end", bus.cfg_end, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_idle", bus.scl, 1'b1);
        fq.delete();
        nq.delete();
        do_write(24'h310311, 0, lat, ack);
        chk("post_lat", lat, 609);
        chk_frame("post", 24'h310311);
        repeat (4) @(negedge clk);
        bus.sda_in = 1'b1;
        do_write(24'h350307, 0, lat, ack);
        bus.sda_in = 1'b0;
`ifdef SCCB_ACK_CHK_EN
        chk("nack_lat", lat, 177);
        chk("nack_ack", ack, 1'b1);
        chk("nack_cnt", fq.size(), 1);
        if (fq.size() > 0) chk("nack_bits", nq.pop_front(), 10);
`else
        chk("nack_lat", lat, 609);
        chk("nack_ack", ack, 1'b0);
        chk_frame("nack", 24'h350307);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
